// File: rtl/sort_engine.sv
// Odd-even transposition sorting network: one compare-exchange layer per register stage,
// N stages deep, accepting one N-element vector per cycle and emitting it sorted ascending.
module sort_engine #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N-1:0][W-1:0] i_data,
  input  logic                i_valid,
  output logic [N-1:0][W-1:0] o_sort_data,
  output logic                o_valid
);

  // Handshake: valid-only, no ready. A vector is accepted on every rising edge where
  // i_valid=1 and i_rst=0; o_valid=1 marks a cycle in which o_sort_data carries a new
  // result. The consumer must take it that cycle because there is no backpressure.

  logic [N-1:0][W-1:0] data_q    [N];
  logic [N-1:0]        valid_q;
  logic [N-1:0][W-1:0] layer_in  [N];
  logic [N-1:0][W-1:0] layer_out [N];
  logic [N-1:0]        valid_in;

  assign valid_in = {valid_q[N-2:0], i_valid};

  // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...; unpaired lanes pass.
  always_comb begin
    for (int s = 0; s < N; s++) begin
      layer_in[s]  = (s == 0) ? i_data : data_q[(s == 0) ? 0 : s - 1];
      layer_out[s] = layer_in[s];
      for (int k = 0; k < N - 1; k++) begin
        if ((k % 2) == (s % 2)) begin
          if (layer_in[s][k] > layer_in[s][k+1]) begin
            layer_out[s][k]   = layer_in[s][k+1];
            layer_out[s][k+1] = layer_in[s][k];
          end
        end
      end
    end
  end

  // Data registers only load on a valid beat so the output holds the last result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      for (int s = 0; s < N; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_in;
      for (int s = 0; s < N; s++) begin
        if (valid_in[s]) begin
          data_q[s] <= layer_out[s];
        end
      end
    end
  end

  assign o_sort_data = data_q[N-1];
  assign o_valid     = valid_q[N-1];

endmodule

// File: tb/tb_sort_engine.sv
// Bench for sort_engine: directed and random vectors feed a scoreboard queue that a
// negedge monitor drains, checking both the sorted data and the exact output cycle.
module tb_sort_engine;
  localparam int N = 8;
  localparam int W = 8;
  typedef logic [N-1:0][W-1:0] vec_t;

  logic i_clk;
  logic i_rst;
  vec_t i_data;
  logic i_valid;
  vec_t o_sort_data;
  logic o_valid;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 0;

  vec_t exp_q[$];
  int   due_q[$];

  sort_engine #(.N(N), .W(W)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_sort_data(o_sort_data),
    .o_valid(o_valid)
  );

  // clock / reset block
  initial begin
    i_clk = 0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic vec_t mk(int e0, int e1, int e2, int e3, int e4, int e5, int e6, int e7);
    vec_t v;
    v[0] = W'(e0); v[1] = W'(e1); v[2] = W'(e2); v[3] = W'(e3);
    v[4] = W'(e4); v[5] = W'(e5); v[6] = W'(e6); v[7] = W'(e7);
    return v;
  endfunction

  // Reference model: plain insertion sort.
  function automatic vec_t ref_sort(vec_t v);
    int a[N];
    int t;
    int j;
    vec_t r;
    for (int i = 0; i < N; i++) a[i] = int'(v[i]);
    for (int i = 1; i < N; i++) begin
      t = a[i];
      j = i - 1;
      while (j >= 0 && a[j] > t) begin
        a[j+1] = a[j];
        j--;
      end
      a[j+1] = t;
    end
    for (int i = 0; i < N; i++) r[i] = W'(a[i]);
    return r;
  endfunction

  task automatic check(input string name, input logic [N*W-1:0] got, input logic [N*W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, want);
    end
  endtask

  // driver tasks
  task automatic send(input vec_t d, input vec_t e);
    @(posedge i_clk); #1;
    i_data  = d;
    i_valid = 1'b1;
    exp_q.push_back(e);
    due_q.push_back(cyc + N);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
      i_valid = 1'b0;
    end
  endtask

  task automatic send_rand();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = W'($urandom);
    send(v, ref_sort(v));
  endtask

  // scoreboard monitor
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("out_cycle", due_q.pop_front(), cyc);
          check("out_data", o_sort_data, exp_q.pop_front());
        end
      end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
        check("missing_valid", 0, 1);
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    vec_t last;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("reset_valid", o_valid, 0);
    check("reset_data", o_sort_data, 0);
    mon_en = 1;
    idle(4);
    check("idle_valid", o_valid, 0);

    // single vector, then output holds
    last = mk(0, 3, 3, 5, 9, 17, 200, 255);
    send(mk(5, 3, 200, 0, 255, 17, 3, 9), last);
    idle(N + 4);
    @(negedge i_clk);
    check("hold_valid", o_valid, 0);
    check("hold_data", o_sort_data, last);

    // ordered edge cases, back to back
    send(mk(0, 1, 2, 3, 4, 5, 6, 7), mk(0, 1, 2, 3, 4, 5, 6, 7));
    send(mk(7, 6, 5, 4, 3, 2, 1, 0), mk(0, 1, 2, 3, 4, 5, 6, 7));
    send(mk(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA),
         mk(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA));
    send(mk(255, 0, 255, 0, 1, 254, 128, 127), mk(0, 0, 1, 127, 128, 254, 255, 255));
    idle(N + 2);

    // streaming
    for (int i = 0; i < 100; i++) send_rand();
    idle(N + 2);

    // gaps
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 1) send_rand();
      else idle(1);
    end
    idle(N + 2);

    // mid-flight reset, with a valid input during the reset cycle
    send(mk(9, 8, 7, 6, 5, 4, 3, 2), mk(2, 3, 4, 5, 6, 7, 8, 9));
    send(mk(1, 1, 1, 1, 1, 1, 1, 0), mk(0, 1, 1, 1, 1, 1, 1, 1));
    send(mk(50, 40, 30, 20, 10, 0, 60, 70), mk(0, 10, 20, 30, 40, 50, 60, 70));
    idle(1);
    @(posedge i_clk); #1;
    exp_q.delete();
    due_q.delete();
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_data  = mk(4, 4, 4, 4, 4, 4, 4, 4);
    @(posedge i_clk); #1;
    i_rst   = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clk);
    check("midrst_data", o_sort_data, 0);
    idle(N + 6);
    send(mk(100, 90, 80, 70, 60, 50, 40, 30), mk(30, 40, 50, 60, 70, 80, 90, 100));
    idle(N + 4);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
